demux_router: RTL and testbench
===============================

Name: demux_router

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshakes; the counterpart of the sign-magnitude datapath's 2:1 select muxes.
- Takes one operand/result stream and steers each word to output channel 0 or 1 according to a per-word select bit.
- Each output channel has its own one-entry holding register, so a stalled channel never blocks traffic routed to the other channel.
- Used to distribute sign-magnitude adder results to separate consumers.

Parameters:
- WIDTH, 8, data word width in bits (sign bit is MSB; the block does not interpret it).
- CNT_W, 8, width of each per-channel transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- select  input  1  destination channel for the current input word (0 → b0, 1 → b1).
- a  input  WIDTH  input data word.
- b0_valid  output  1  channel 0 holding register full.
- b0_ready  input  1  channel 0 consumer accepts.
- b0  output  WIDTH  channel 0 data.
- b1_valid  output  1  channel 1 holding register full.
- b1_ready  input  1  channel 1 consumer accepts.
- b1  output  WIDTH  channel 1 data.
- cnt0  output  CNT_W  words accepted for channel 0.
- cnt1  output  CNT_W  words accepted for channel 1.

Behaviour:
- Clock and reset: single clock domain, clk; reset rst is asynchronous and active-high.
- Reset values: b0_valid=0, b1_valid=0, b0=0, b1=0, cnt0=0, cnt1=0. Assertion mid-operation clears all of these immediately; held words are discarded.
- Per-channel state: EMPTY (valid=0) or FULL (valid=1). Per channel k:
  - pop_k = bk_valid & bk_ready.
  - load_k = in_valid & in_ready & (select==k).
- Ready is combinational from current state only, not from in_valid:
  - in_ready = (select==0) ? (!b0_valid | b0_ready) : (!b1_valid | b1_ready).
  - in_ready is low during reset.
- Transitions per channel:
  - EMPTY + load → FULL; bk <= a.
  - FULL + pop, no load → EMPTY; bk keeps its last value.
  - FULL + pop + load in the same cycle → stays FULL; bk <= a. This is back-to-back with no bubble.
  - FULL + no pop → hold. bk and bk_valid stay stable while bk_valid=1 and bk_ready=0.
- Latency: a word accepted on edge N is visible on bk with bk_valid=1 after edge N; one cycle.
- Isolation:
  - A stalled channel deasserts in_ready only for words selected to it.
  - Words selected to the other channel still flow.
  - No reordering within a channel; at most one word is accepted per cycle.
- select and a are don't-care when in_valid=0. in_valid may drop without a transfer; no sticky request.
- Counters:
  - cntk increments by 1 on each load_k edge.
  - Wraps modulo 2^CNT_W: 255 → 0 at the default width.
  - Pops do not affect the counters.
- Outputs b0, b1, bk_valid and cntk are registered. in_ready is the only combinational output.

Test Plan:
- Reset and idle:
  - Assert rst mid-cycle → all valids, data and counters read 0 immediately, without waiting for a clock edge.
  - After release with in_valid=0 → outputs hold 0 for 10 cycles.
- Basic routing with both ready held at 1:
  - Send a=8'h85, select=0 → b0=8'h85, b0_valid=1 one cycle later, b1_valid stays 0.
  - Then send a=8'h07, select=1 → b1=8'h07, cnt0=1, cnt1=1.
- Stall and isolation with b0_ready=0:
  - Send 8'h11 to channel 0 → b0_valid=1.
  - Present 8'h22 to channel 0 → in_ready=0; b0 stays 8'h11 for 5 cycles.
  - Switch to select=1, a=8'h33 → in_ready=1 and b1=8'h33 the next cycle.
- Simultaneous pop and load: channel 0 FULL with 8'h44, b0_ready=1, input 8'h55 to channel 0 in the same cycle → b0_valid stays 1, b0=8'h55, cnt0 increments by 1.
- Counter wrap: accept 256 consecutive words to channel 1 → cnt1 goes 255 → 0 and cnt0 is unchanged.
- Random soak: 1000 cycles with random valid/ready/select → scoreboard matches per-channel order and data, and counters equal the scoreboard push counts mod 256.

Source files
------------

// File: rtl/demux_router.sv
// Registered 1-to-2 demultiplexer: each input word goes to channel 0 or 1 by its
// select bit, and each channel has its own one-entry holding register and transfer counter.
module demux_router #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             select,
    input  logic [WIDTH-1:0] a,
    output logic             b0_valid,
    input  logic             b0_ready,
    output logic [WIDTH-1:0] b0,
    output logic             b1_valid,
    input  logic             b1_ready,
    output logic [WIDTH-1:0] b1,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

    chan_state_t state0, state1;
    logic        pop0, pop1, load0, load1;

    // Handshake: a word moves on a rising edge where valid and ready are both high.
    // in_ready looks only at the selected channel's state and its consumer's ready,
    // never at in_valid, so a stalled channel blocks only words aimed at it.
    assign b0_valid = (state0 == FULL);
    assign b1_valid = (state1 == FULL);
    assign in_ready = !rst && (select ? (!b1_valid || b1_ready) : (!b0_valid || b0_ready));

    assign pop0  = b0_valid && b0_ready;
    assign pop1  = b1_valid && b1_ready;
    assign load0 = in_valid && in_ready && !select;
    assign load1 = in_valid && in_ready && select;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state0 <= EMPTY;
            state1 <= EMPTY;
            b0     <= '0;
            b1     <= '0;
            cnt0   <= '0;
            cnt1   <= '0;
        end else begin
            // A load into a FULL channel implies that same cycle's pop, so the
            // channel stays FULL with the new word and no bubble.
            case (state0)
                EMPTY: if (load0) begin
                    state0 <= FULL;
                    b0     <= a;
                end
                FULL: if (load0) begin
                    b0 <= a;
                end else if (pop0) begin
                    state0 <= EMPTY;
                end
            endcase

            case (state1)
                EMPTY: if (load1) begin
                    state1 <= FULL;
                    b1     <= a;
                end
                FULL: if (load1) begin
                    b1 <= a;
                end else if (pop1) begin
                    state1 <= EMPTY;
                end
            endcase

            if (load0) cnt0 <= cnt0 + CNT_W'(1);
            if (load1) cnt1 <= cnt1 + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_demux_router.sv
// Bench for demux_router: directed scenarios plus a random soak, all checked against
// a queue-based model of each channel (accepted words not yet consumed) and load counts.
module tb_demux_router;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             select;
    logic [WIDTH-1:0] a;
    logic             b0_valid;
    logic             b0_ready;
    logic [WIDTH-1:0] b0;
    logic             b1_valid;
    logic             b1_ready;
    logic [WIDTH-1:0] b1;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    int n_vec;
    int n_err;

    // Reference model: per-channel queue of accepted, unconsumed words; last word
    // delivered to each channel; number of words accepted per channel.
    logic [WIDTH-1:0] exp_q0[$];
    logic [WIDTH-1:0] exp_q1[$];
    logic [WIDTH-1:0] last0, last1;
    int               loads0, loads1;

    demux_router #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .select   (select),
        .a        (a),
        .b0_valid (b0_valid),
        .b0_ready (b0_ready),
        .b0       (b0),
        .b1_valid (b1_valid),
        .b1_ready (b1_ready),
        .b1       (b1),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model helpers ----------------
    function automatic void model_reset();
        exp_q0.delete();
        exp_q1.delete();
        last0  = '0;
        last1  = '0;
        loads0 = 0;
        loads1 = 0;
    endfunction

    // A channel can take a word if nothing is waiting in it or its consumer takes
    // the waiting word this cycle.
    function automatic bit model_ready();
        if (select) return (exp_q1.size() == 0) || b1_ready;
        return (exp_q0.size() == 0) || b0_ready;
    endfunction

    function automatic logic [CNT_W-1:0] model_cnt(input int loads);
        return CNT_W'(loads % (1 << CNT_W));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic settle();
        #1;
    endtask

    // Advance one clock edge with the current inputs and update the model.
    task automatic tick();
        bit               acc, p0, p1, sel;
        logic [WIDTH-1:0] word;
        p0   = (exp_q0.size() != 0) && b0_ready;
        p1   = (exp_q1.size() != 0) && b1_ready;
        acc  = in_valid && model_ready();
        sel  = select;
        word = a;
        @(posedge clk);
        if (p0) void'(exp_q0.pop_front());
        if (p1) void'(exp_q1.pop_front());
        if (acc) begin
            if (sel) begin
                exp_q1.push_back(word);
                last1 = word;
                loads1++;
            end else begin
                exp_q0.push_back(word);
                last0 = word;
                loads0++;
            end
        end
        #1;
    endtask

    task automatic send(input bit sel, input logic [WIDTH-1:0] data);
        in_valid = 1'b1;
        select   = sel;
        a        = data;
        settle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        select   = 1'b0;
        a        = '0;
        b0_ready = 1'b0;
        b1_ready = 1'b0;
        model_reset();
        #3;
        n_vec++;
        if ({b0_valid, b1_valid, b0, b1, cnt0, cnt1, in_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_initial: got v0=%b v1=%b b0=%h b1=%h c0=%0d c1=%0d rdy=%b, want all 0",
                     b0_valid, b1_valid, b0, b1, cnt0, cnt1, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load one word into each channel, then reset mid-cycle.
        send(1'b0, 8'h5a);
        tick();
        send(1'b1, 8'ha5);
        tick();
        in_valid = 1'b0;
        settle();
        n_vec++;
        if ({b0_valid, b1_valid} !== 2'b11) begin
            n_err++;
            $display("FAIL reset_preload: got valids=%b%b, want 11", b0_valid, b1_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_vec++;
        if ({b0_valid, b1_valid, b0, b1, cnt0, cnt1, in_ready} !== '0) begin
            n_err++;
            $display("FAIL reset_async: got v0=%b v1=%b b0=%h b1=%h c0=%0d c1=%0d rdy=%b, want all 0",
                     b0_valid, b1_valid, b0, b1, cnt0, cnt1, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if ({b0_valid, b1_valid, b0, b1, cnt0, cnt1} !== '0) begin
                n_err++;
                $display("FAIL idle_hold cycle %0d: got v0=%b v1=%b b0=%h b1=%h c0=%0d c1=%0d, want all 0",
                         i, b0_valid, b1_valid, b0, b1, cnt0, cnt1);
            end
        end
    endtask

    task automatic test_basic_routing();
        b0_ready = 1'b1;
        b1_ready = 1'b1;
        send(1'b0, 8'h85);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_ready0: got in_ready=%b, want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        settle();
        n_vec++;
        if ({b0_valid, b0, b1_valid} !== {1'b1, 8'h85, 1'b0}) begin
            n_err++;
            $display("FAIL basic_ch0: got v0=%b b0=%h v1=%b, want v0=1 b0=85 v1=0", b0_valid, b0, b1_valid);
        end
        send(1'b1, 8'h07);
        tick();
        in_valid = 1'b0;
        settle();
        n_vec++;
        if ({b1_valid, b1, cnt0, cnt1} !== {1'b1, 8'h07, 8'd1, 8'd1}) begin
            n_err++;
            $display("FAIL basic_ch1: got v1=%b b1=%h c0=%0d c1=%0d, want v1=1 b1=07 c0=1 c1=1",
                     b1_valid, b1, cnt0, cnt1);
        end
        tick();
    endtask

    task automatic test_stall_isolation();
        b0_ready = 1'b0;
        b1_ready = 1'b1;
        send(1'b0, 8'h11);
        tick();
        n_vec++;
        if ({b0_valid, b0} !== {1'b1, 8'h11}) begin
            n_err++;
            $display("FAIL stall_load: got v0=%b b0=%h, want v0=1 b0=11", b0_valid, b0);
        end
        send(1'b0, 8'h22);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_ready: got in_ready=%b, want 0", in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if ({b0_valid, b0, in_ready} !== {1'b1, 8'h11, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold cycle %0d: got v0=%b b0=%h rdy=%b, want v0=1 b0=11 rdy=0",
                         i, b0_valid, b0, in_ready);
            end
        end
        send(1'b1, 8'h33);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL isolate_ready: got in_ready=%b, want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        settle();
        n_vec++;
        if ({b1_valid, b1, b0_valid, b0} !== {1'b1, 8'h33, 1'b1, 8'h11}) begin
            n_err++;
            $display("FAIL isolate_route: got v1=%b b1=%h v0=%b b0=%h, want v1=1 b1=33 v0=1 b0=11",
                     b1_valid, b1, b0_valid, b0);
        end
        b0_ready = 1'b1;
        tick();
        n_vec++;
        if (b0_valid !== 1'b0 || b0 !== 8'h11) begin
            n_err++;
            $display("FAIL drain_keep: got v0=%b b0=%h, want v0=0 b0=11", b0_valid, b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [CNT_W-1:0] c0_before;
        b0_ready = 1'b0;
        send(1'b0, 8'h44);
        tick();
        b0_ready  = 1'b1;
        c0_before = cnt0;
        send(1'b0, 8'h55);
        n_vec++;
        if ({b0_valid, b0, in_ready} !== {1'b1, 8'h44, 1'b1}) begin
            n_err++;
            $display("FAIL b2b_pre: got v0=%b b0=%h rdy=%b, want v0=1 b0=44 rdy=1", b0_valid, b0, in_ready);
        end
        tick();
        in_valid = 1'b0;
        b0_ready = 1'b0;
        settle();
        n_vec++;
        if ({b0_valid, b0, cnt0} !== {1'b1, 8'h55, c0_before + 8'd1}) begin
            n_err++;
            $display("FAIL b2b_post: got v0=%b b0=%h c0=%0d, want v0=1 b0=55 c0=%0d",
                     b0_valid, b0, cnt0, c0_before + 8'd1);
        end
        b0_ready = 1'b1;
        tick();
    endtask

    task automatic test_counter_wrap();
        logic [CNT_W-1:0] c0_before, c1_prev;
        bit               saw_wrap;
        b1_ready  = 1'b1;
        c0_before = cnt0;
        saw_wrap  = 1'b0;
        for (int i = 0; i < 256; i++) begin
            c1_prev = cnt1;
            send(1'b1, WIDTH'($urandom));
            tick();
            if (c1_prev == 8'hff && cnt1 == 8'h00) saw_wrap = 1'b1;
            n_vec++;
            if (cnt1 !== model_cnt(loads1) || b1 !== last1) begin
                n_err++;
                $display("FAIL wrap_step %0d: got c1=%0d b1=%h, want c1=%0d b1=%h",
                         i, cnt1, b1, model_cnt(loads1), last1);
            end
        end
        in_valid = 1'b0;
        settle();
        n_vec++;
        if (!saw_wrap || cnt0 !== c0_before) begin
            n_err++;
            $display("FAIL wrap_final: got saw_wrap=%b c0=%0d, want saw_wrap=1 c0=%0d", saw_wrap, cnt0, c0_before);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            select   = $urandom_range(0, 1);
            a        = WIDTH'($urandom);
            b0_ready = ($urandom_range(0, 2) != 0);
            b1_ready = ($urandom_range(0, 2) != 0);
            settle();
            n_vec++;
            if (in_ready !== model_ready()) begin
                n_err++;
                $display("FAIL rand_ready cycle %0d: got %b, want %b", i, in_ready, model_ready());
            end
            n_vec++;
            if (b0_valid !== (exp_q0.size() != 0) || b1_valid !== (exp_q1.size() != 0)) begin
                n_err++;
                $display("FAIL rand_valid cycle %0d: got %b%b, want %b%b",
                         i, b0_valid, b1_valid, exp_q0.size() != 0, exp_q1.size() != 0);
            end
            if (exp_q0.size() != 0) begin
                n_vec++;
                if (b0 !== exp_q0[0]) begin
                    n_err++;
                    $display("FAIL rand_data0 cycle %0d: got %h, want %h", i, b0, exp_q0[0]);
                end
            end
            if (exp_q1.size() != 0) begin
                n_vec++;
                if (b1 !== exp_q1[0]) begin
                    n_err++;
                    $display("FAIL rand_data1 cycle %0d: got %h, want %h", i, b1, exp_q1[0]);
                end
            end
            n_vec++;
            if (cnt0 !== model_cnt(loads0) || cnt1 !== model_cnt(loads1)) begin
                n_err++;
                $display("FAIL rand_cnt cycle %0d: got %0d/%0d, want %0d/%0d",
                         i, cnt0, cnt1, model_cnt(loads0), model_cnt(loads1));
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic_routing();
        test_stall_isolation();
        test_back_to_back();
        test_counter_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
